// File: rtl/zap_decode_skid_stage_if.sv
// rtl/zap_decode_skid_stage_if.sv - upstream/downstream handshake bundle for the decode skid stage
interface zap_decode_skid_stage_if #(
  parameter int PAYLOAD_W = 160,
  parameter int DEPTH     = 2
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                 i_valid;
  logic                 o_ready;
  logic [PAYLOAD_W-1:0] i_payload;
  logic [3:0]           i_cc;
  logic                 i_irq;
  logic                 i_fiq;
  logic                 i_abt;
  logic                 i_und;
  logic                 o_valid;
  logic [PAYLOAD_W-1:0] o_payload;
  logic [3:0]           o_cc;
  logic                 o_irq;
  logic                 o_fiq;
  logic                 o_abt;
  logic                 o_und;
  logic [LVL_W-1:0]     o_level;

  modport master (
    output i_valid, i_payload, i_cc, i_irq, i_fiq, i_abt, i_und,
    input  o_ready, o_valid, o_payload, o_cc, o_irq, o_fiq, o_abt, o_und, o_level
  );

  modport slave (
    input  i_valid, i_payload, i_cc, i_irq, i_fiq, i_abt, i_und,
    output o_ready, o_valid, o_payload, o_cc, o_irq, o_fiq, o_abt, o_und, o_level
  );
endinterface

// File: rtl/zap_decode_skid_stage.sv
// rtl/zap_decode_skid_stage.sv - decode output register with prioritised clear/stall and skid FIFO
// Optional counters enabled by ZAP_DECODE_SKID_PERF_EN.
module zap_decode_skid_stage #(
  parameter int                PAYLOAD_W  = 160,
  parameter int                DEPTH      = 2,
  parameter int                NUM_CTRL   = 5,
  parameter logic [NUM_CTRL-1:0] CLEAR_MASK = 5'b00101
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic [NUM_CTRL-1:0] i_ctrl,
  input  logic                i_cpsr_i,
  input  logic                i_cpsr_f,
  zap_decode_skid_stage_if.slave bus
`ifdef ZAP_DECODE_SKID_PERF_EN
  ,
  output logic [31:0]         o_stall_cycles,
  output logic [15:0]         o_clear_count
`endif
);
  localparam int PTR_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [3:0]           cc;
    logic                 irq;
    logic                 fiq;
    logic                 abt;
    logic                 und;
  } ent_t;

  typedef enum logic [1:0] {ACT_ADV, ACT_STALL, ACT_CLEAR} act_e;

  ent_t             mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, level;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic             valid_q, valid_d;
  ent_t             out_q, out_d, in_ent, ld_ent;
  logic             ld_en, wr_en, push, empty;
  act_e             act;

  // Scanning high to low leaves the lowest-index set bit as the winner.
  always_comb begin
    act = ACT_ADV;
    for (int k = NUM_CTRL - 1; k >= 0; k--) begin
      if (i_ctrl[k]) act = CLEAR_MASK[k] ? ACT_CLEAR : ACT_STALL;
    end
  end

  assign level       = wr_ptr_q - rd_ptr_q;
  assign empty       = (level == '0);
  assign bus.o_ready = (level != PTR_W'(DEPTH));
  assign push        = bus.i_valid & bus.o_ready & (act != ACT_CLEAR);
  assign rd_idx      = (DEPTH == 1) ? '0 : rd_ptr_q[IDX_W-1:0];
  assign wr_idx      = (DEPTH == 1) ? '0 : wr_ptr_q[IDX_W-1:0];
  assign in_ent      = '{payload: bus.i_payload, cc: bus.i_cc, irq: bus.i_irq,
                         fiq: bus.i_fiq, abt: bus.i_abt, und: bus.i_und};

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    valid_d  = valid_q;
    out_d    = out_q;
    ld_en    = 1'b0;
    ld_ent   = in_ent;
    wr_en    = 1'b0;
    case (act)
      ACT_CLEAR: begin
        rd_ptr_d = '0;
        wr_ptr_d = '0;
        valid_d  = 1'b0;
        out_d    = '{payload: out_q.payload, cc: 4'hF, default: 1'b0};
      end
      ACT_STALL: begin
        wr_en = push;
      end
      default: begin
        if (!empty) begin
          ld_en    = 1'b1;
          ld_ent   = mem_q[rd_idx];
          rd_ptr_d = rd_ptr_q + 1'b1;
          wr_en    = push;
        end else if (push) begin
          ld_en = 1'b1;
        end else begin
          valid_d = 1'b0;
          out_d   = '{payload: out_q.payload, cc: 4'hF, default: 1'b0};
        end
      end
    endcase
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    // Interrupt masks are applied at load time so a late CPSR change still takes effect.
    if (ld_en) begin
      valid_d = 1'b1;
      out_d   = '{payload: ld_ent.payload, cc: ld_ent.cc, irq: ld_ent.irq & ~i_cpsr_i,
                  fiq: ld_ent.fiq & ~i_cpsr_f, abt: ld_ent.abt, und: ld_ent.und};
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_idx] <= in_ent;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      valid_q  <= 1'b0;
      out_q    <= '{payload: '0, cc: 4'hF, default: 1'b0};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      valid_q  <= valid_d;
      out_q    <= out_d;
    end
  end

  assign bus.o_valid   = valid_q;
  assign bus.o_payload = out_q.payload;
  assign bus.o_cc      = out_q.cc;
  assign bus.o_irq     = out_q.irq;
  assign bus.o_fiq     = out_q.fiq;
  assign bus.o_abt     = out_q.abt;
  assign bus.o_und     = out_q.und;
  assign bus.o_level   = level;

`ifdef ZAP_DECODE_SKID_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [15:0] clear_cnt_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stall_cnt_q <= '0;
      clear_cnt_q <= '0;
    end else begin
      if (act == ACT_STALL && valid_q && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (act == ACT_CLEAR && clear_cnt_q != '1) clear_cnt_q <= clear_cnt_q + 1'b1;
    end
  end

  assign o_stall_cycles = stall_cnt_q;
  assign o_clear_count  = clear_cnt_q;
`endif
endmodule

// File: doc/zap_decode_skid_stage.md
Name: zap_decode_skid_stage

Overview:
Parametrised successor to the decode-stage output flop bank. It registers a PAYLOAD_W-bit decoded bundle plus condition code and exception flags, and resolves any number of prioritised clear/stall sources from a parameter mask. A DEPTH-entry skid FIFO with valid/ready handshake lets fetch/decode keep streaming while downstream (issue/shifter/memory) stalls. It sits between the decoder core and the issue stage.

Parameters:
PAYLOAD_W, 160, width of the opaque decoded bundle (indices, ALU/shift ops, mem controls, PCs).
DEPTH, 2, skid FIFO entries; power of two, >=1.
NUM_CTRL, 5, number of prioritised pipeline-control sources.
CLEAR_MASK, 5'b00101, bit k=1: source k is a clear; bit k=0: source k is a stall.

Ports:
i_clk  in  1  clock.
i_reset_n  in  1  asynchronous active-low reset.
i_ctrl  in  NUM_CTRL  control sources; bit 0 highest priority.
i_cpsr_i  in  1  current CPSR I mask.
i_cpsr_f  in  1  current CPSR F mask.
i_valid  in  1  upstream bundle valid.
o_ready  out  1  upstream may push this cycle.
i_payload  in  PAYLOAD_W  decoded bundle.
i_cc  in  4  condition code.
i_irq, i_fiq, i_abt, i_und  in  1 each  raw exception flags.
o_valid  out  1  output register holds a live bundle.
o_payload  out  PAYLOAD_W  registered bundle.
o_cc  out  4  registered condition code; NV (4'hF) when empty/cleared.
o_irq, o_fiq, o_abt, o_und  out  1 each  registered exception flags.
o_level  out  $clog2(DEPTH)+1  skid FIFO occupancy.

Behaviour:
- Reset (async, i_reset_n=0): o_valid=0, o_cc=4'hF, exception flags 0, o_payload=0, FIFO empty, o_level=0; o_ready=1 once reset deasserts.
- Action per cycle: lowest-index set bit k of i_ctrl selects CLEAR if CLEAR_MASK[k] else STALL; no bit set selects ADVANCE. Lower-priority bits are ignored.
- o_ready = (o_level < DEPTH), combinational from the registered count; push only when i_valid & o_ready.
- CLEAR: o_valid<=0, o_cc<=NV, all exception flags<=0, FIFO flushed, o_level<=0. The input bundle that cycle is discarded. o_payload is unchanged.
- STALL: the output register holds. A push writes the FIFO tail.
- ADVANCE, FIFO non-empty: pop the head into the output register; a simultaneous push goes to the tail, so o_level is unchanged.
- ADVANCE, FIFO empty with push: bypass the input into the output register. Latency is 1 cycle.
- ADVANCE, nothing available: o_valid<=0, o_cc<=NV, flags<=0.
- Loading the output register: o_irq <= irq & ~i_cpsr_i, o_fiq <= fiq & ~i_cpsr_f, using the CPSR value at load time, not at push time. o_und <= und (entries are valid by construction). o_abt passes unmasked.
- FIFO stores {payload, cc, irq, fiq, abt, und}. Read/write pointers are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full when o_level==DEPTH. Order is strictly FIFO.
- Full FIFO under STALL: o_ready=0 and no write.
- Full FIFO under ADVANCE: a pop occurs, but o_ready was 0 at the start of the cycle, so there is no push. o_level decrements.

Optional Feature:
ZAP_DECODE_SKID_PERF_EN
- Defined: adds o_stall_cycles[31:0] and o_clear_count[15:0]. o_stall_cycles counts STALL cycles with o_valid=1. o_clear_count counts CLEAR cycles. Both saturate at all-ones and reset to 0.
- Undefined: neither port nor counter exists; no other behaviour changes.

Test Plan:
- Reset release, i_valid=1, payload=0x1, cc=4'h0, no ctrl -> next cycle o_valid=1, o_payload=0x1, o_cc=0, o_level=0.
- i_ctrl=5'b01000 (stall) for 3 cycles, pushing A,B,C with DEPTH=2 -> A,B accepted, o_level=2, o_ready=0 on cycle 3, C not taken. Release -> A,B emerge in order on consecutive cycles.
- FIFO holds 2 entries, i_ctrl=5'b00100 (clear) -> next cycle o_valid=0, o_cc=4'hF, o_level=0, o_ready=1.
- i_ctrl=5'b01001 (bit0 clear, bit3 stall) -> clear wins. i_ctrl=5'b01100 -> bit 2 clear wins over bit 3 stall.
- i_irq=1 pushed while i_cpsr_i=0 and held in FIFO; i_cpsr_i=1 before pop -> on load o_irq=0. With i_cpsr_i=0 -> o_irq=1. o_abt=1 is passed regardless.
- PERF_EN defined: 4 stall cycles with o_valid=1, then 1 clear -> o_stall_cycles=4, o_clear_count=1.
